// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU control decoder and the mul/div sequencer:
// aluctrl codes, funct/aluop encodings, sequencer state and decoded HI/LO operation.
package alu_pkg;

    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_SLT    = 4'b0111;
    localparam logic [3:0] ALU_MFHI   = 4'b1000;
    localparam logic [3:0] ALU_MFLO   = 4'b1001;
    localparam logic [3:0] ALU_NOP_HL = 4'b1010;
    localparam logic [3:0] ALU_NOR    = 4'b1100;
    localparam logic [3:0] ALU_ERR    = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_BAD   = 2'b11;

    localparam logic [5:0] FUN_MFHI  = 6'b010000;
    localparam logic [5:0] FUN_MTHI  = 6'b010001;
    localparam logic [5:0] FUN_MFLO  = 6'b010010;
    localparam logic [5:0] FUN_MTLO  = 6'b010011;
    localparam logic [5:0] FUN_MULT  = 6'b011000;
    localparam logic [5:0] FUN_MULTU = 6'b011001;
    localparam logic [5:0] FUN_DIV   = 6'b011010;
    localparam logic [5:0] FUN_DIVU  = 6'b011011;
    localparam logic [5:0] FUN_ADD   = 6'b100000;
    localparam logic [5:0] FUN_ADDU  = 6'b100001;
    localparam logic [5:0] FUN_SUB   = 6'b100010;
    localparam logic [5:0] FUN_SUBU  = 6'b100011;
    localparam logic [5:0] FUN_AND   = 6'b100100;
    localparam logic [5:0] FUN_OR    = 6'b100101;
    localparam logic [5:0] FUN_NOR   = 6'b100111;
    localparam logic [5:0] FUN_SLT   = 6'b101010;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_FIN  = 2'd2
    } seq_state_t;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_t;

    // True for the operations that occupy the iterative sequencer.
    function automatic logic md_is_seq(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning HI/LO. One bit per cycle on operand
// magnitudes; the sign fix-up is applied while writing HI/LO on the final RUN edge.
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output seq_state_t       state,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    seq_state_t       state_reg;
    logic [CW-1:0]    count_reg;
    logic             busy_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;

    // p_hi holds the partial product / running remainder (one guard bit),
    // p_lo holds the multiplier / dividend being shifted out.
    logic [WIDTH:0]   p_hi_reg;
    logic [WIDTH-1:0] p_lo_reg;
    logic [WIDTH-1:0] opnd_reg;
    logic [WIDTH-1:0] a_raw_reg;
    logic             is_div_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             div0_reg;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH:0]     p_hi_next;
    logic [WIDTH-1:0]   p_lo_next;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_fin;
    logic [WIDTH-1:0]   lo_fin;

    always_comb begin
        signed_op = (op == MD_MULT) || (op == MD_DIV);
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        mag_a     = a_neg ? -a : a;
        mag_b     = b_neg ? -b : b;
    end

    always_comb begin
        mul_sum   = p_lo_reg[0] ? (p_hi_reg + {1'b0, opnd_reg}) : p_hi_reg;
        div_shift = {p_hi_reg[WIDTH-1:0], p_lo_reg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_reg};
        if (is_div_reg) begin
            // Restoring step: keep the difference only when it did not borrow.
            if (!div_diff[WIDTH]) begin
                p_hi_next = div_diff;
                p_lo_next = {p_lo_reg[WIDTH-2:0], 1'b1};
            end else begin
                p_hi_next = div_shift;
                p_lo_next = {p_lo_reg[WIDTH-2:0], 1'b0};
            end
        end else begin
            p_hi_next = {1'b0, mul_sum[WIDTH:1]};
            p_lo_next = {mul_sum[0], p_lo_reg[WIDTH-1:1]};
        end

        product     = {p_hi_next[WIDTH-1:0], p_lo_next};
        product_fix = neg_q_reg ? -product : product;
        quot_fix    = neg_q_reg ? -p_lo_next : p_lo_next;
        rem_fix     = neg_r_reg ? -p_hi_next[WIDTH-1:0] : p_hi_next[WIDTH-1:0];

        if (!is_div_reg) begin
            hi_fin = product_fix[2*WIDTH-1:WIDTH];
            lo_fin = product_fix[WIDTH-1:0];
        end else if (div0_reg) begin
            hi_fin = a_raw_reg;
            lo_fin = '1;
        end else begin
            hi_fin = rem_fix;
            lo_fin = quot_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= SEQ_IDLE;
            count_reg  <= '0;
            busy_reg   <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            p_hi_reg   <= '0;
            p_lo_reg   <= '0;
            opnd_reg   <= '0;
            a_raw_reg  <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            div0_reg   <= 1'b0;
        end else begin
            case (state_reg)
                SEQ_IDLE: begin
                    if (valid && md_is_seq(op)) begin
                        state_reg  <= SEQ_RUN;
                        count_reg  <= CW'(WIDTH);
                        busy_reg   <= 1'b1;
                        p_hi_reg   <= '0;
                        p_lo_reg   <= mag_a;
                        opnd_reg   <= mag_b;
                        a_raw_reg  <= a;
                        is_div_reg <= (op == MD_DIV) || (op == MD_DIVU);
                        neg_q_reg  <= a_neg ^ b_neg;
                        neg_r_reg  <= a_neg;
                        div0_reg   <= (b == '0);
                    end else if (valid && op == MD_MTHI) begin
                        hi_reg <= a;
                    end else if (valid && op == MD_MTLO) begin
                        lo_reg <= a;
                    end
                end
                SEQ_RUN: begin
                    // A flushed instruction abandons the operation without touching HI/LO.
                    if (!valid) begin
                        state_reg <= SEQ_IDLE;
                        count_reg <= '0;
                        busy_reg  <= 1'b0;
                    end else begin
                        p_hi_reg  <= p_hi_next;
                        p_lo_reg  <= p_lo_next;
                        count_reg <= count_reg - CW'(1);
                        if (count_reg == CW'(1)) begin
                            state_reg <= SEQ_FIN;
                            hi_reg    <= hi_fin;
                            lo_reg    <= lo_fin;
                        end
                    end
                end
                SEQ_FIN: begin
                    state_reg <= SEQ_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= SEQ_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign state = state_reg;
    assign busy  = busy_reg;
    assign hi    = hi_reg;
    assign lo    = lo_reg;

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// EX-stage ALU control: combinational aluop/funct decode and pipeline stall,
// with the HI/LO multiply/divide sequencer instantiated underneath.
module alu_muldiv_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [1:0]       aluop,
    input  logic [5:0]       fun,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       aluctrl,
    output logic             ctrl_err,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_op_t     md_op;
    seq_state_t seq_state;

    always_comb begin
        aluctrl  = ALU_ERR;
        ctrl_err = 1'b1;
        md_op    = MD_NONE;
        case (aluop)
            ALUOP_ADD: begin
                aluctrl  = ALU_ADD;
                ctrl_err = 1'b0;
            end
            ALUOP_SUB: begin
                aluctrl  = ALU_SUB;
                ctrl_err = 1'b0;
            end
            ALUOP_RTYPE: begin
                ctrl_err = 1'b0;
                case (fun)
                    FUN_ADD, FUN_ADDU: aluctrl = ALU_ADD;
                    FUN_SUB, FUN_SUBU: aluctrl = ALU_SUB;
                    FUN_AND:           aluctrl = ALU_AND;
                    FUN_OR:            aluctrl = ALU_OR;
                    FUN_SLT:           aluctrl = ALU_SLT;
                    FUN_NOR:           aluctrl = ALU_NOR;
                    FUN_MFHI:          aluctrl = ALU_MFHI;
                    FUN_MFLO:          aluctrl = ALU_MFLO;
                    FUN_MTHI: begin
                        aluctrl = ALU_NOP_HL;
                        md_op   = MD_MTHI;
                    end
                    FUN_MTLO: begin
                        aluctrl = ALU_NOP_HL;
                        md_op   = MD_MTLO;
                    end
                    FUN_MULT: begin
                        aluctrl = ALU_NOP_HL;
                        md_op   = MD_MULT;
                    end
                    FUN_MULTU: begin
                        aluctrl = ALU_NOP_HL;
                        md_op   = MD_MULTU;
                    end
                    FUN_DIV: begin
                        aluctrl = ALU_NOP_HL;
                        md_op   = MD_DIV;
                    end
                    FUN_DIVU: begin
                        aluctrl = ALU_NOP_HL;
                        md_op   = MD_DIVU;
                    end
                    default: begin
                        aluctrl  = ALU_ERR;
                        ctrl_err = 1'b1;
                    end
                endcase
            end
            default: begin
                aluctrl  = ALU_ERR;
                ctrl_err = 1'b1;
            end
        endcase
    end

    // The issuing instruction is held until the sequencer reaches FIN, where it retires.
    assign stall = valid & md_is_seq(md_op) & (seq_state != SEQ_FIN);

    muldiv_seq #(
        .WIDTH(WIDTH)
    ) u_seq (
        .clk  (clk),
        .rst  (rst),
        .valid(valid),
        .op   (md_op),
        .a    (a),
        .b    (b),
        .state(seq_state),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Directed plus randomized checks of decode, HI/LO moves, mul/div results, stall timing,
// abort and reset, against a plain-arithmetic reference model.
module tb_alu_muldiv_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid;
    logic [1:0]  aluop;
    logic [5:0]  fun;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluctrl;
    logic        ctrl_err;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        valid8;
    logic [1:0]  aluop8;
    logic [5:0]  fun8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [3:0]  aluctrl8;
    logic        ctrl_err8;
    logic        stall8;
    logic        busy8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    alu_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .valid(valid), .aluop(aluop), .fun(fun), .a(a), .b(b),
        .aluctrl(aluctrl), .ctrl_err(ctrl_err), .stall(stall), .busy(busy), .hi(hi), .lo(lo)
    );

    alu_muldiv_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .valid(valid8), .aluop(aluop8), .fun(fun8), .a(a8), .b(b8),
        .aluctrl(aluctrl8), .ctrl_err(ctrl_err8), .stall(stall8), .busy(busy8), .hi(hi8), .lo(lo8)
    );

    int          checks = 0;
    int          fails = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // {ctrl_err, aluctrl} straight from the decode table.
    function automatic logic [4:0] dec_model(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 5'b0_0010;
        if (op == 2'b01) return 5'b0_0110;
        if (op == 2'b11) return 5'b1_1111;
        case (f)
            6'b100000, 6'b100001: return 5'b0_0010;
            6'b100010, 6'b100011: return 5'b0_0110;
            6'b100100:            return 5'b0_0000;
            6'b100101:            return 5'b0_0001;
            6'b101010:            return 5'b0_0111;
            6'b100111:            return 5'b0_1100;
            6'b010000:            return 5'b0_1000;
            6'b010010:            return 5'b0_1001;
            6'b010001, 6'b010011, 6'b011000, 6'b011001, 6'b011010, 6'b011011: return 5'b0_1010;
            default:              return 5'b1_1111;
        endcase
    endfunction

    // {hi, lo} for a completed mul/div, using 64-bit signed/unsigned arithmetic.
    function automatic logic [63:0] md_model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint q;
        longint r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (f)
            F_MULT: begin
                p = 64'(sx * sy);
                return p;
            end
            F_MULTU: begin
                p = {32'b0, x} * {32'b0, y};
                return p;
            end
            default: begin
                if (y == 32'b0) return {x, 32'hFFFF_FFFF};
                if (f == F_DIVU) return {x % y, x / y};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Issues one mul/div and follows it to retirement, or drops valid in RUN cycle abort_at.
    task automatic run_md(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                          input int abort_at);
        int n;
        logic [63:0] r;
        valid = 1'b1; aluop = 2'b10; fun = f; a = x; b = y;
        #1;
        n = 0;
        while (n < 100 && stall === 1'b1) begin
            check("busy_during_op", busy, (n != 0));
            if (n == abort_at) begin
                valid = 1'b0;
                #1;
                check("abort_stall", stall, 1'b0);
                @(posedge clk); #2;
                check("abort_busy", busy, 1'b0);
                check("abort_hi", hi, exp_hi);
                check("abort_lo", lo, exp_lo);
                $display("op fun=%b a=%h b=%h aborted at run cycle %0d", f, x, y, n);
                return;
            end
            n++;
            @(posedge clk); #2;
        end
        r = md_model(f, x, y);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        check("stall_cycles", n, 33);
        check("fin_busy", busy, 1'b1);
        check("fin_hi", hi, exp_hi);
        check("fin_lo", lo, exp_lo);
        // Next instruction reads HI with no extra latency.
        fun = F_MFHI;
        #1;
        check("mfhi_ctrl", aluctrl, 4'b1000);
        check("mfhi_stall", stall, 1'b0);
        @(posedge clk); #2;
        check("idle_busy", busy, 1'b0);
        check("idle_hi", hi, exp_hi);
        valid = 1'b0;
        $display("op fun=%b a=%h b=%h -> hi=%h lo=%h (stall %0d cycles)", f, x, y, hi, lo, n);
    endtask

    initial begin
        int n;
        logic [4:0] d;
        logic [5:0] fsel [4];
        logic [5:0] f;
        logic [31:0] x;
        logic [31:0] y;
        fsel[0] = F_MULT; fsel[1] = F_MULTU; fsel[2] = F_DIV; fsel[3] = F_DIVU;

        rst = 1'b1; valid = 1'b0; aluop = '0; fun = '0; a = '0; b = '0;
        valid8 = 1'b0; aluop8 = '0; fun8 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_stall", stall, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 256; i++) begin
            aluop = i[7:6];
            fun   = i[5:0];
            #1;
            d = dec_model(aluop, fun);
            check("dec_aluctrl", aluctrl, d[3:0]);
            check("dec_err", ctrl_err, d[4]);
        end
        $display("decode sweep of 256 aluop/fun combinations done");
        @(posedge clk); #2;

        // HI/LO moves complete in one cycle and never stall.
        valid = 1'b1; aluop = 2'b10; fun = F_MTHI; a = 32'h1234_5678;
        #1;
        check("mthi_stall", stall, 1'b0);
        @(posedge clk); #2;
        exp_hi = 32'h1234_5678;
        fun = F_MTLO; a = 32'd9;
        #1;
        check("mtlo_stall", stall, 1'b0);
        check("mthi_hi", hi, exp_hi);
        @(posedge clk); #2;
        exp_lo = 32'd9;
        fun = F_MFLO;
        #1;
        check("mflo_ctrl", aluctrl, 4'b1001);
        check("mflo_stall", stall, 1'b0);
        check("mtlo_lo", lo, exp_lo);
        check("mtlo_hi", hi, exp_hi);
        $display("mthi/mtlo -> hi=%h lo=%h", hi, lo);
        valid = 1'b0;
        @(posedge clk); #2;

        run_md(F_MULT, 32'hFFFF_FFFD, 32'd7, -1);
        check("mult_m3x7_hi", hi, 32'hFFFF_FFFF);
        check("mult_m3x7_lo", lo, 32'hFFFF_FFEB);
        run_md(F_DIV, 32'hFFFF_FFF9, 32'd2, -1);
        check("div_m7d2_lo", lo, 32'hFFFF_FFFD);
        check("div_m7d2_hi", hi, 32'hFFFF_FFFF);
        run_md(F_DIVU, 32'd7, 32'd0, -1);
        check("divu_7d0_lo", lo, 32'hFFFF_FFFF);
        check("divu_7d0_hi", hi, 32'd7);
        run_md(F_DIV, 32'hFFFF_FFF0, 32'd0, -1);
        run_md(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        check("div_mn_lo", lo, 32'h8000_0000);
        check("div_mn_hi", hi, 32'h0);
        run_md(F_DIV, 32'd100, 32'hFFFF_FFF9, -1);

        run_md(F_MULTU, 32'hDEAD_BEEF, 32'h0BAD_F00D, 10);
        run_md(F_MULT, 32'h7FFF_FFFF, 32'h8000_0000, -1);

        for (int i = 0; i < 12; i++) begin
            f = fsel[$urandom_range(3, 0)];
            x = $urandom;
            y = $urandom;
            if (i % 4 == 1) y = y >> $urandom_range(31, 20);
            if (i == 6) y = 32'b0;
            run_md(f, x, y, -1);
        end

        // Reset in the middle of RUN clears everything.
        valid = 1'b1; aluop = 2'b10; fun = F_MULTU; a = 32'h0000_0123; b = 32'h0000_0456;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1; valid = 1'b0;
        @(posedge clk); #2;
        exp_hi = '0;
        exp_lo = '0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_hi", hi, exp_hi);
        check("midrst_lo", lo, exp_lo);
        check("midrst_stall", stall, 1'b0);
        $display("reset mid-run -> busy=%b hi=%h lo=%h", busy, hi, lo);
        rst = 1'b0;
        @(posedge clk); #2;

        valid8 = 1'b1; aluop8 = 2'b10; fun8 = F_MULTU; a8 = 8'hFF; b8 = 8'hFF;
        #1;
        n = 0;
        while (n < 50 && stall8 === 1'b1) begin
            n++;
            @(posedge clk); #2;
        end
        check("w8_stall_cycles", n, 9);
        check("w8_hi", hi8, 8'hFE);
        check("w8_lo", lo8, 8'h01);
        $display("width8 multu ff*ff -> hi=%h lo=%h (stall %0d cycles)", hi8, lo8, n);
        valid8 = 1'b0;
        @(posedge clk); #2;

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_ctrl.md
# alu_muldiv_ctrl

Parametrised successor to the single-cycle ALU control decoder. It decodes aluop/fun into an extended aluctrl code set, adding nor, addu/subu and HI/LO access. It also owns an iterative multiply/divide sequencer with HI/LO registers and a stall handshake. It sits in the EX stage between main control and the ALU/register-file write mux.

## Interface
- WIDTH, 32, operand and HI/LO width (≥4). Mul/div iteration count equals WIDTH.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- valid  in  1  EX-stage instruction is live. Low = bubble or flush.
- aluop  in  2  from main control
- fun  in  6  instruction funct field
- a  in  WIDTH  rs operand
- b  in  WIDTH  rt operand
- aluctrl  out  4  ALU operation code, combinational
- ctrl_err  out  1  undecodable aluop/fun, combinational
- stall  out  1  hold PC/IF/ID/EX, combinational from state and inputs
- busy  out  1  sequencer not IDLE, registered
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- Decode, independent of valid:
  - aluop 00 → 0010
  - aluop 01 → 0110
  - aluop 11 → 1111 with ctrl_err
  - aluop 10, by fun:
    - 100000/100001 (add/addu) → 0010
    - 100010/100011 (sub/subu) → 0110
    - 100100 → 0000
    - 100101 → 0001
    - 101010 → 0111
    - 100111 (nor) → 1100
    - 010000 (mfhi) → 1000, write-back mux selects hi
    - 010010 (mflo) → 1001, selects lo
    - 010001/010011 (mthi/mtlo) and 011000–011011 (mult, multu, div, divu) → 1010, no ALU result
    - any other fun → 1111 with ctrl_err
- mthi/mtlo: when valid and state IDLE, hi (or lo) ← a at the clock edge. No stall.
- mult/multu: shift-add on magnitudes, one bit per cycle. Signed: negate the 2·WIDTH product if sign(a)^sign(b). {hi,lo} ← product.
- div/divu: restoring division on magnitudes, one bit per cycle. lo ← quotient, hi ← remainder.
  - Signed: quotient negated if signs differ; remainder takes sign of a.
- Divide by zero, signed or unsigned: lo ← all ones, hi ← a. No sign correction.
- Signed most-negative ÷ −1: lo = most-negative, hi = 0. No error signalled.
- FSM:
  - IDLE: valid & mul/div op → RUN. Latch magnitudes, signs, op kind; count ← WIDTH.
  - RUN: one iteration per cycle, count−1. At count==1 → FIN, writing hi/lo with sign correction at that edge.
  - FIN → IDLE unconditionally.
- stall = valid & mul/div op & state≠FIN. Covers IDLE issue and all RUN cycles.
- Abort: valid low in RUN → IDLE next edge. hi/lo unchanged, no partial write.
- rst overrides everything: state IDLE, count 0, hi = lo = 0, busy 0.

## Timing
- Mul/div issued in cycle t (IDLE):
  - stall high in cycles t … t+WIDTH (WIDTH+1 cycles)
  - RUN t+1 … t+WIDTH
  - FIN t+WIDTH+1: stall low, instruction retires, new hi/lo visible
  - IDLE again at t+WIDTH+2
- busy high t+1 … t+WIDTH+1.
- Back-to-back mul/div: the second issues in t+WIDTH+2; FIN never re-triggers.
- mfhi/mflo directly after FIN read the new value, zero extra latency.
- mthi/mtlo while not IDLE: ignored. Cannot occur while the pipeline is held.
- aluctrl, ctrl_err and stall are purely combinational. hi, lo and busy are registered.

## Structure
- Shared package alu_pkg:
  - aluctrl code constants (ADD, SUB, AND, OR, SLT, NOR, MFHI, MFLO, NOP_HL, ERR)
  - funct constants
  - aluop constants
  - sequencer state enum
- Sub-module muldiv_seq, parametrised by WIDTH: FSM, counter, iterative datapath, sign correction, hi/lo.
- Top level holds the combinational decoder and the stall equation.

## Test plan
- Decode sweep, all 256 {aluop,fun}: add→0010, nor→1100, mflo→1001, fun 111111→1111 with ctrl_err=1; aluop 01 with any fun → 0110.
- mult a=−3, b=7, WIDTH=32:
  - stall high exactly 33 cycles
  - FIN: hi=FFFFFFFF, lo=FFFFFFEB
- div a=−7, b=2 → lo=FFFFFFFD, hi=FFFFFFFF. divu a=7, b=0 → lo=FFFFFFFF, hi=7.
- mthi a=12345678, then mflo after mtlo a=9 → hi=12345678, lo=9, stall never asserted.
- valid dropped in RUN cycle 10 → IDLE next cycle; hi/lo keep prior values; a following mult completes normally.
- rst asserted mid-RUN → next cycle busy=0, hi=lo=0, stall=0 with valid low. Repeat at WIDTH=8: multu FF×FF → hi=FE, lo=01.
